mem_responder: RTL

Request/response memory target for the lab datapath: accepts read and write transactions on a valid/ready request channel, services them from internal 32-bit storage with the same sync-write/async-read character as the distributed-memory IP, and returns read data on a valid/ready response channel. It is the target side of the memory interface that CPU and testbench initiators drive. It isolates initiators from raw `a`/`d`/`we`/`spo` timing and adds backpressure.

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder_array.sv | 34 +++
 rtl/mem_responder.sv | 92 +++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder slice: bus widths,
// the error fill pattern, the response state type and an address range helper.
package mem_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } rsp_state_t;

   // True when a word address falls inside the implemented storage.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
      return int'(addr) < depth;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface mem_responder_if import mem_pkg::*; ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/mem_responder_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read, and a
// synchronous reset that reloads every word with INIT_VAL.
module mem_array import mem_pkg::*; #(
   parameter int                DEPTH    = 32,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              hit;

   assign hit   = addr_in_range(addr, DEPTH);
   assign rdata = hit ? mem[addr[IDX_W-1:0]] : '0;

   // Reset wins over a write in the same cycle; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= INIT_VAL;
         end
      end else if (we && hit) begin
         mem[addr[IDX_W-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory target with valid/ready request and response channels.
// A one-deep response register is held in HOLD until the initiator consumes it.
// Build option: define MEM_RSP_WRITE_ACK_EN to make writes return an
// acknowledge response (rdata = write data) instead of being posted silently.
module mem_responder import mem_pkg::*; #(
   parameter int                DEPTH    = 32,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   mem_responder_if.slave   bus,
   output logic [15:0]      txn_cnt
);

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_HOLD = HOLD;

`ifdef MEM_RSP_WRITE_ACK_EN
   localparam logic WRITE_ACK = 1'b1;
`else
   localparam logic WRITE_ACK = 1'b0;
`endif

   logic [0:0]        state;
   logic              fire;
   logic              in_range;
   logic              mem_we;
   logic              load_rsp;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] rsp_data_next;
   logic              rsp_err_next;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;

   // Ready depends only on state and rsp_ready so there is no loop through req_valid.
   assign bus.req_ready = (state == ST_IDLE) || bus.rsp_ready;
   assign fire          = bus.req_valid && bus.req_ready;
   assign in_range      = addr_in_range(bus.req_addr, DEPTH);
   assign mem_we        = fire && bus.req_we && in_range;
   assign load_rsp      = fire && (!bus.req_we || WRITE_ACK);

   assign bus.rsp_valid = (state == ST_HOLD);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   mem_array #(
      .DEPTH    (DEPTH),
      .INIT_VAL (INIT_VAL)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .addr  (bus.req_addr),
      .wdata (bus.req_wdata),
      .rdata (mem_rdata)
   );

   // Response payload: stored word for reads, echoed data for write acks, error fill when out of range.
   always_comb begin
      rsp_data_next = ERR_DATA;
      rsp_err_next  = 1'b1;
      if (in_range) begin
         rsp_err_next  = 1'b0;
         rsp_data_next = bus.req_we ? bus.req_wdata : mem_rdata;
      end
   end

   // Response register and state: a new response reloads, a consume without a new one empties.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (load_rsp) begin
         state       <= ST_HOLD;
         rsp_rdata_q <= rsp_data_next;
         rsp_err_q   <= rsp_err_next;
      end else if (bus.rsp_ready) begin
         state       <= ST_IDLE;
      end
   end

   // Counts every accepted request regardless of type or address; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         txn_cnt <= '0;
      end else if (fire) begin
         txn_cnt <= txn_cnt + 16'd1;
      end
   end

endmodule
